moving_average_filter: RTL and testbench
========================================

// Module: moving_average_filter
// PURPOSE
//  Stereo N-tap moving-average (noise) filter between the audio_codec read port and write port.
//  Pulls one sample pair per codec read handshake and filters each channel independently.
//  Pushes the filtered pair back via the codec write handshake.
//  Drops in at top level in place of the pass-through wiring (read/write/readdata/writedata).
// PARAMETERS
//  DATA_W  24  sample width, two's complement, both channels
//  LOG2_N  3   log2 of tap count; N = 2**LOG2_N (default 8 taps)
// PORTS
//  CLOCK_50         in   1       system clock; all state on rising edge
//  reset_n          in   1       asynchronous, active-low reset
//  read_ready       in   1       codec: ADC sample pair available
//  write_ready      in   1       codec: DAC FIFO has room
//  readdata_left    in   DATA_W  codec ADC left sample
//  readdata_right   in   DATA_W  codec ADC right sample
//  read             out  1       pop one ADC pair (single-cycle pulse)
//  write            out  1       push one DAC pair (single-cycle pulse)
//  writedata_left   out  DATA_W  filtered left sample, registered
//  writedata_right  out  DATA_W  filtered right sample, registered
// BEHAVIOUR
//  Reset (async on reset_n=0):
//   - state=S_IDLE; read=0, write=0 (immediately); writedata_*=0.
//   - Accumulators=0; FIFO pointers and fill count=0.
//  FSM, one sample pair per pass:
//   - S_IDLE: read = read_ready (combinational). On that edge, capture readdata_* into in_*; go S_CALC.
//   - S_CALC, exactly 1 cycle, per channel:
//     - t = in >>> LOG2_N (arithmetic shift, truncates toward -inf).
//     - If FIFO full: pop oldest o; acc <= acc + t - o. Else acc <= acc + t (warm-up; missing taps = 0).
//     - Push t; writedata_* <= next acc value. Go S_WRITE.
//   - S_WRITE: write = write_ready (combinational). On that edge, go S_IDLE.
//  read and write are never high in the same cycle; each is high at most 1 cycle per pass.
//  Latency: 1 cycle read edge->writedata valid; write asserts the first cycle after that with write_ready=1.
//  Backpressure: write_ready low holds S_WRITE and writedata_*; no new read meanwhile.
//  Width: acc is DATA_W signed; the sum of N terms each ≤ |2^(DATA_W-1)/N| cannot overflow, so no saturation.
//  FIFO: depth N, never pushed when full without a same-cycle pop; count saturates at N after warm-up.
//  Channels: left and right share the FSM but have separate acc and FIFO; no cross-coupling.
//  Reset mid-pass (any state): everything clears; the pending pair is discarded and warm-up restarts.
// STRUCTURE
//  - Shared package audio_pkg: FSM state encoding (S_IDLE, S_CALC, S_WRITE), default DATA_W=24.
//  - Sub-module sample_delay_fifo(DATA_W, LOG2_N):
//    - Circular buffer with wrap-around rd/wr pointers, count, full/empty flags.
//    - Same-cycle push+pop legal when full.
//    - Instantiated once per channel.
//  - Top of this block: FSM, input capture, two accumulators, output registers.
// TESTING
//  1. reset_n=0 at any time -> read=0, write=0, writedata_*=0 same cycle.
//  2. N=8, left=800 every sample -> outputs 100,200,...,800 then steady 800.
//  3. Right=-8 every sample -> -1,-2,...,-8 then steady -8; left=800 unaffected.
//  4. Impulse left=24'h7FFFF8, then zeros -> 24'h0FFFFF for 8 outputs, then 0 (tests FIFO wrap).
//  5. Hold write_ready=0 for 20 cycles in S_WRITE -> write=0, read=0, writedata held.
//     Then raise write_ready -> exactly 1 write pulse.
//  6. Pulse reset_n low in S_CALC after 5 samples -> state clears; next 800 input yields 100 (warm-up restarted).

Source files
------------

// File: rtl/audio_pkg.sv
// Shared definitions for the audio filter path: FSM state encoding and default widths.
package audio_pkg;

  localparam int DATA_W_DEF = 24;
  localparam int LOG2_N_DEF = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_WRITE = 2'd2
  } state_e;

endpackage

// File: rtl/moving_average_filter_if.sv
// Codec read/write handshake bundle; the filter is the master, the codec side is the slave.
interface moving_average_filter_if
  import audio_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic              read_ready;
  logic              write_ready;
  logic [DATA_W-1:0] readdata_left;
  logic [DATA_W-1:0] readdata_right;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata_left;
  logic [DATA_W-1:0] writedata_right;

  modport master (
    input  read_ready,
    input  write_ready,
    input  readdata_left,
    input  readdata_right,
    output read,
    output write,
    output writedata_left,
    output writedata_right
  );

  modport slave (
    output read_ready,
    output write_ready,
    output readdata_left,
    output readdata_right,
    input  read,
    input  write,
    input  writedata_left,
    input  writedata_right
  );

endinterface

// File: rtl/sample_delay_fifo.sv
// Circular delay line of the last 2**LOG2_N scaled samples for one channel.
module sample_delay_fifo
  import audio_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LOG2_N = LOG2_N_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full
);

  localparam int              DEPTH    = 1 << LOG2_N;
  localparam logic [LOG2_N:0] FULL_CNT = (LOG2_N + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [LOG2_N-1:0] wr_ptr_r;
  logic [LOG2_N-1:0] rd_ptr_r;
  logic [LOG2_N:0]   count_r;
  logic              full_s;
  logic              empty_s;
  logic              push_ok_s;
  logic              pop_ok_s;

  // A push while full is only accepted when the oldest entry leaves in the same cycle.
  always_comb begin
    full_s    = (count_r == FULL_CNT);
    empty_s   = (count_r == {(LOG2_N + 1){1'b0}});
    pop_ok_s  = pop & ~empty_s;
    push_ok_s = push & (~full_s | pop_ok_s);
  end

  assign full = full_s;
  assign dout = mem_r[rd_ptr_r];

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {LOG2_N{1'b0}};
      rd_ptr_r <= {LOG2_N{1'b0}};
      count_r  <= {(LOG2_N + 1){1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + LOG2_N'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + LOG2_N'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + (LOG2_N + 1)'(1);
        2'b01:   count_r <= count_r - (LOG2_N + 1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/moving_average_filter.sv
// Stereo N-tap moving-average filter sitting between the codec ADC read port and DAC write port.
module moving_average_filter
  import audio_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LOG2_N = LOG2_N_DEF
) (
  input  logic                     CLOCK_50,
  input  logic                     reset_n,
  moving_average_filter_if.master  codec
);

  state_e state_r;
  state_e next_state_s;

  logic read_s;
  logic write_s;
  logic push_s;
  logic pop_left_s;
  logic pop_right_s;
  logic full_left_s;
  logic full_right_s;

  logic signed [DATA_W-1:0] in_left_r;
  logic signed [DATA_W-1:0] in_right_r;
  logic signed [DATA_W-1:0] acc_left_r;
  logic signed [DATA_W-1:0] acc_right_r;
  logic signed [DATA_W-1:0] wd_left_r;
  logic signed [DATA_W-1:0] wd_right_r;
  logic signed [DATA_W-1:0] tap_left_s;
  logic signed [DATA_W-1:0] tap_right_s;
  logic signed [DATA_W-1:0] old_left_s;
  logic signed [DATA_W-1:0] old_right_s;
  logic signed [DATA_W-1:0] acc_left_next_s;
  logic signed [DATA_W-1:0] acc_right_next_s;

  // State register.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic: one sample pair per IDLE -> CALC -> WRITE pass.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (read_s) begin
          next_state_s = S_CALC;
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_CALC: next_state_s = S_WRITE;
      S_WRITE: begin
        if (write_s) begin
          next_state_s = S_IDLE;
        end else begin
          next_state_s = S_WRITE;
        end
      end
      default: next_state_s = S_IDLE;
    endcase
  end

  // Handshake strobes are gated by reset_n so they drop in the same cycle reset is asserted.
  always_comb begin
    read_s  = 1'b0;
    write_s = 1'b0;
    push_s  = 1'b0;
    case (state_r)
      S_IDLE:  read_s  = codec.read_ready & reset_n;
      S_CALC:  push_s  = 1'b1;
      S_WRITE: write_s = codec.write_ready & reset_n;
      default: begin
        read_s  = 1'b0;
        write_s = 1'b0;
        push_s  = 1'b0;
      end
    endcase
  end

  // Running sums: add the newest scaled tap, retire the oldest once the window is full.
  always_comb begin
    tap_left_s  = in_left_r >>> LOG2_N;
    tap_right_s = in_right_r >>> LOG2_N;
    pop_left_s  = push_s & full_left_s;
    pop_right_s = push_s & full_right_s;
    if (full_left_s) begin
      acc_left_next_s = acc_left_r + tap_left_s - old_left_s;
    end else begin
      acc_left_next_s = acc_left_r + tap_left_s;
    end
    if (full_right_s) begin
      acc_right_next_s = acc_right_r + tap_right_s - old_right_s;
    end else begin
      acc_right_next_s = acc_right_r + tap_right_s;
    end
  end

  // Input capture, accumulators and registered outputs.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      in_left_r   <= {DATA_W{1'b0}};
      in_right_r  <= {DATA_W{1'b0}};
      acc_left_r  <= {DATA_W{1'b0}};
      acc_right_r <= {DATA_W{1'b0}};
      wd_left_r   <= {DATA_W{1'b0}};
      wd_right_r  <= {DATA_W{1'b0}};
    end else begin
      if (read_s) begin
        in_left_r  <= codec.readdata_left;
        in_right_r <= codec.readdata_right;
      end
      if (push_s) begin
        acc_left_r  <= acc_left_next_s;
        acc_right_r <= acc_right_next_s;
        wd_left_r   <= acc_left_next_s;
        wd_right_r  <= acc_right_next_s;
      end
    end
  end

  sample_delay_fifo #(
    .DATA_W (DATA_W),
    .LOG2_N (LOG2_N)
  ) u_fifo_left (
    .clk   (CLOCK_50),
    .rst_n (reset_n),
    .push  (push_s),
    .pop   (pop_left_s),
    .din   (tap_left_s),
    .dout  (old_left_s),
    .full  (full_left_s)
  );

  sample_delay_fifo #(
    .DATA_W (DATA_W),
    .LOG2_N (LOG2_N)
  ) u_fifo_right (
    .clk   (CLOCK_50),
    .rst_n (reset_n),
    .push  (push_s),
    .pop   (pop_right_s),
    .din   (tap_right_s),
    .dout  (old_right_s),
    .full  (full_right_s)
  );

  assign codec.read            = read_s;
  assign codec.write           = write_s;
  assign codec.writedata_left  = wd_left_r;
  assign codec.writedata_right = wd_right_r;

endmodule

// File: tb/tb_moving_average_filter.sv
// Scoreboard bench for moving_average_filter: a windowed-sum model predicts each written pair.
module tb_moving_average_filter;
  import audio_pkg::*;

  localparam int DW = 24;
  localparam int LN = 3;
  localparam int N  = 8;
  localparam int WAIT_MAX = 50;

  typedef struct packed {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
  } pair_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  moving_average_filter_if #(.DATA_W(DW)) bus ();

  moving_average_filter #(
    .DATA_W (DW),
    .LOG2_N (LN)
  ) dut (
    .CLOCK_50 (clk),
    .reset_n  (rst_n),
    .codec    (bus)
  );

  pair_t sb[$];
  int    hist_l[$];
  int    hist_r[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  logic [DW-1:0] got_l;
  logic [DW-1:0] got_r;

  task automatic model_clear();
    hist_l.delete();
    hist_r.delete();
    sb.delete();
  endtask

  // Expected output = plain sum over the last N scaled samples (zeros before warm-up).
  task automatic model_push(input logic signed [DW-1:0] l, input logic signed [DW-1:0] r);
    int sl;
    int sr;
    pair_t p;
    hist_l.push_back(int'(l >>> LN));
    hist_r.push_back(int'(r >>> LN));
    if (hist_l.size() > N) void'(hist_l.pop_front());
    if (hist_r.size() > N) void'(hist_r.pop_front());
    sl = 0;
    sr = 0;
    foreach (hist_l[i]) sl += hist_l[i];
    foreach (hist_r[i]) sr += hist_r[i];
    p.l = sl[DW-1:0];
    p.r = sr[DW-1:0];
    sb.push_back(p);
  endtask

  task automatic drive_read(input logic [DW-1:0] l, input logic [DW-1:0] r);
    int cnt;
    cnt = 0;
    bus.readdata_left  = l;
    bus.readdata_right = r;
    bus.read_ready     = 1'b1;
    #1;
    while (bus.read !== 1'b1 && cnt < WAIT_MAX) begin
      @(negedge clk);
      cnt++;
    end
    n_checks++;
    if (cnt >= WAIT_MAX || bus.write !== 1'b0)
      $display("FAIL read_wait: read=%b write=%b after %0d cycles, required read=1 write=0", bus.read, bus.write, cnt);
    else begin
      n_pass++;
      model_push(l, r);
    end
    @(negedge clk);
    bus.read_ready = 1'b0;
  endtask

  task automatic drive_write(output logic [DW-1:0] ol, output logic [DW-1:0] orr);
    int cnt;
    pair_t e;
    cnt = 0;
    ol  = '0;
    orr = '0;
    bus.write_ready = 1'b1;
    #1;
    while (bus.write !== 1'b1 && cnt < WAIT_MAX) begin
      @(negedge clk);
      cnt++;
    end
    n_checks++;
    if (cnt >= WAIT_MAX || sb.size() == 0)
      $display("FAIL write_wait: write=%b after %0d cycles, expected entries=%0d", bus.write, cnt, sb.size());
    else begin
      n_pass++;
      e   = sb.pop_front();
      ol  = bus.writedata_left;
      orr = bus.writedata_right;
      n_checks++;
      if (ol !== e.l) $display("FAIL sb_left: got %h required %h", ol, e.l);
      else n_pass++;
      n_checks++;
      if (orr !== e.r) $display("FAIL sb_right: got %h required %h", orr, e.r);
      else n_pass++;
      n_checks++;
      if (bus.read !== 1'b0) $display("FAIL read_during_write: got %b required 0", bus.read);
      else n_pass++;
    end
    @(negedge clk);
    bus.write_ready = 1'b0;
    #1;
    n_checks++;
    if (bus.write !== 1'b0) $display("FAIL write_pulse_width: got %b required 0", bus.write);
    else n_pass++;
  endtask

  task automatic do_pass(input logic [DW-1:0] l, input logic [DW-1:0] r);
    drive_read(l, r);
    drive_write(got_l, got_r);
  endtask

  task automatic test_reset();
    bus.read_ready  = 1'b1;
    bus.write_ready = 1'b1;
    bus.readdata_left  = 24'd800;
    bus.readdata_right = 24'd800;
    #3;
    n_checks++;
    if (bus.read !== 1'b0 || bus.write !== 1'b0)
      $display("FAIL reset_strobes: read=%b write=%b required 0 0", bus.read, bus.write);
    else n_pass++;
    n_checks++;
    if (bus.writedata_left !== 24'd0 || bus.writedata_right !== 24'd0)
      $display("FAIL reset_data: got %h/%h required 0/0", bus.writedata_left, bus.writedata_right);
    else n_pass++;
    bus.read_ready  = 1'b0;
    bus.write_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_dc_stereo();
    int k;
    logic [DW-1:0] el;
    logic [DW-1:0] er;
    for (int i = 0; i < 12; i++) begin
      do_pass(24'd800, -24'sd8);
      k  = (i + 1 < N) ? i + 1 : N;
      el = DW'(100 * k);
      er = DW'(-k);
      n_checks++;
      if (got_l !== el) $display("FAIL dc_left[%0d]: got %0d required %0d", i, got_l, el);
      else n_pass++;
      n_checks++;
      if (got_r !== er) $display("FAIL dc_right[%0d]: got %h required %h", i, got_r, er);
      else n_pass++;
    end
  endtask

  task automatic test_impulse();
    logic [DW-1:0] el;
    for (int i = 0; i < N; i++) do_pass(24'd0, 24'd0);
    for (int j = 0; j < 11; j++) begin
      do_pass((j == 0) ? 24'h7FFFF8 : 24'h000000, 24'd0);
      el = (j < N) ? 24'h0FFFFF : 24'h000000;
      n_checks++;
      if (got_l !== el) $display("FAIL impulse[%0d]: got %h required %h", j, got_l, el);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    drive_read(24'd800, -24'sd8);
    bus.readdata_left  = 24'd1234;
    bus.readdata_right = 24'd5678;
    bus.read_ready     = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_checks++;
      if (bus.write !== 1'b0 || bus.read !== 1'b0)
        $display("FAIL backpressure_strobes[%0d]: read=%b write=%b required 0 0", c, bus.read, bus.write);
      else n_pass++;
      n_checks++;
      if (sb.size() == 0 || bus.writedata_left !== sb[0].l || bus.writedata_right !== sb[0].r)
        $display("FAIL backpressure_hold[%0d]: got %h/%h", c, bus.writedata_left, bus.writedata_right);
      else n_pass++;
    end
    bus.read_ready = 1'b0;
    drive_write(got_l, got_r);
  endtask

  task automatic test_reset_mid();
    rst_n = 1'b0;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) do_pass(24'd800, -24'sd8);
    drive_read(24'd800, -24'sd8);
    bus.read_ready  = 1'b1;
    bus.write_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.read !== 1'b0 || bus.write !== 1'b0 || bus.writedata_left !== 24'd0 || bus.writedata_right !== 24'd0)
      $display("FAIL reset_mid_clear: read=%b write=%b data=%h/%h required 0 0 0/0",
               bus.read, bus.write, bus.writedata_left, bus.writedata_right);
    else n_pass++;
    model_clear();
    @(negedge clk);
    bus.read_ready  = 1'b0;
    bus.write_ready = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    do_pass(24'd800, -24'sd8);
    n_checks++;
    if (got_l !== 24'd100 || got_r !== 24'hFFFFFF)
      $display("FAIL reset_mid_warmup: got %0d/%h required 100/ffffff", got_l, got_r);
    else n_pass++;
  endtask

  initial begin
    bus.read_ready     = 1'b0;
    bus.write_ready    = 1'b0;
    bus.readdata_left  = '0;
    bus.readdata_right = '0;
    test_reset();
    test_dc_stereo();
    test_impulse();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
